mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage of the 5-stage RISC-V pipeline: consumes the EX/MEM register outputs, performs load/store transactions on a single-outstanding data-memory bus, and holds the MEM/WB pipeline register feeding writeback. Stalls the front of the pipeline while a memory transaction is in flight. Sign/zero-extends load data and generates byte enables for sub-word stores.

## Interface
- No parameters; all widths are fixed by RV32I.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous and active-high; clears state and all registered outputs.
- ALUResultM  in  32  effective address or ALU result.
- WriteDataM  in  32  store data, unaligned (rs2 value).
- RdM  in  5  destination register.
- PCPlus4M  in  32  return address for jal/jalr.
- CtrlM  in  4  [3]=RegWrite, [2:1]=ResultSrc (00 ALU, 01 load, 10 PC+4), [0]=MemWrite.
- Funct3M  in  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- dmem_req  out  1  request valid; held until dmem_rvalid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address, {ALUResultM[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read word, valid with dmem_rvalid.
- dmem_rvalid  in  1  completion pulse for loads and stores.
- StallM  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM.
- MisalignM  out  1  combinational; access fault flag.
- ALUResultW, ReadDataW, PCPlus4W  out  32 each; RdW  out  5; CtrlW  out  3  [2]=RegWrite, [1:0]=ResultSrc.

## Operation
- Access = load (ResultSrc==01) or store (MemWrite). Non-access instructions pass M→W in one cycle without touching the bus.
- Misaligned: h/hu with addr[0]=1; w with addr[1:0]≠0; funct3 outside the legal set on an access. Result: MisalignM=1, no bus request, StallM=0; W receives a bubble (CtrlW=0, others 0).
- Store lanes: sb be=0001<<addr[1:0], wdata={4{byte}}; sh be=0011 (addr[1]=0) or 1100, wdata={2{half}}; sw be=1111.
- Load extract: byte/half selected by addr[1:0]/addr[1]; b/h sign-extend, bu/hu zero-extend, w passes through. Loads drive be=1111.
- FSM states: IDLE, WAIT.
  - IDLE, legal access: dmem_req=1, StallM=1, go to WAIT. dmem_rvalid is ignored in IDLE.
  - WAIT: dmem_req held with stable address, data, and enables; StallM=!dmem_rvalid.
  - WAIT, dmem_rvalid=1: StallM=0; W captures the instruction, with the load result in ReadDataW (stores: ReadDataW=0); go to IDLE.
- While StallM=1, W loads a bubble every cycle. Upstream holds M inputs constant; the block relies on this.

## Timing
- Non-access or misaligned instruction: latency 1 (M at cycle t, W valid at t+1).
- Memory access with rvalid k≥1 cycles after first req: W valid at t+k+1; StallM high for cycles t..t+k-1.
- Back-to-back accesses: next request issues in the cycle immediately after the rvalid cycle (IDLE re-entered); no dead cycle.
- Reset (async, any time, including mid-WAIT): state→IDLE, dmem_req=0 immediately, all W outputs 0, StallM=0 while rst is high. A late dmem_rvalid after reset is ignored, because IDLE ignores rvalid.
- Output widths: ReadDataW is always a full 32 bits after extension; no truncation elsewhere.

## Structure
- Shared riscv_pkg holds:
  - Funct3 load/store constants.
  - ResultSrc encodings.
  - CtrlM/CtrlW bit-index localparams.
  - The mem_state_e enum {IDLE, WAIT}.
- One sub-module, load_align: combinational extraction and extension of (rdata, addr[1:0], funct3) into 32-bit data. The store lane/byte-enable logic stays inline.

## Test plan
- ALU op: CtrlM=1000, ALUResultM=0x1234, RdM=5 → next cycle ALUResultW=0x1234, RdW=5, CtrlW=100, StallM never high.
- lb at 0x103 with rvalid 2 cycles after req, rdata=0x80xxxxxx → StallM high 2 cycles, dmem_addr=0x100, ReadDataW=0xFFFFFF80; lbu on same data gives 0x00000080.
- sh at 0x202 with WriteDataM=0xABCD1234 → be=1100, wdata=0x12341234, dmem_we=1, CtrlW RegWrite=0.
- lw at 0x301 → MisalignM=1, dmem_req stays 0, StallM=0, W bubble (CtrlW=000).
- Back-to-back: sw then lw, each with 1-cycle memory latency → second req asserts in the cycle after the first rvalid; both W results correct.
- Reset asserted mid-WAIT, then a stray rvalid → dmem_req drops asynchronously, W outputs 0, state IDLE, and the stray rvalid produces no W update.

Source files
------------

// File: rtl/riscv_pkg.sv
// Purpose: shared RV32I encodings and types for the MEM/WB stage (funct3, ResultSrc, control bit indices, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // Load/store access size and sign (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    // CtrlM = {RegWrite, ResultSrc[1:0], MemWrite}
    localparam int CTRLM_REGWRITE = 3;
    localparam int CTRLM_RES_HI   = 2;
    localparam int CTRLM_RES_LO   = 1;
    localparam int CTRLM_MEMWRITE = 0;

    // CtrlW = {RegWrite, ResultSrc[1:0]}
    localparam int CTRLW_REGWRITE = 2;
    localparam int CTRLW_RES_HI   = 1;
    localparam int CTRLW_RES_LO   = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Unsigned variants only exist for loads; stores accept b/h/w.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Purpose: single-outstanding data-memory bus between the MEM stage (master) and data memory (slave).
// Latency: n/a (wires only).
// Backpressure: req is held until the rvalid completion pulse; one transaction in flight.
// Signals: dmem_req/we/addr/be/wdata (master->slave), dmem_rdata/rvalid (slave->master).
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_rvalid
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_rvalid
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Purpose: extract byte/half/word from a read word by address offset and sign/zero-extend to 32 bits.
// Latency: combinational.
// Backpressure: none.
// Ports: i_rdata (read word), i_addr_lo (byte offset), i_funct3 (size/sign), o_data (extended result).
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = 32'h0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0, w_half};
            F3_W:    o_data = i_rdata;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Purpose: RV32I memory stage: issues loads/stores on the dmem bus and holds the MEM/WB register.
// Latency: 1 cycle for non-access/misaligned; k+1 cycles for an access completed k cycles after req.
// Backpressure: StallM freezes upstream while a transaction is outstanding; W takes bubbles meanwhile.
// Ports: clk/rst; EX/MEM inputs (ALUResultM, WriteDataM, RdM, PCPlus4M, CtrlM, Funct3M);
//        dmem master port; StallM/MisalignM; MEM/WB outputs (ALUResultW, ReadDataW, PCPlus4W, RdW, CtrlW).
module mem_wb_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic [3:0]  CtrlM,
    input  logic [2:0]  Funct3M,
    mem_wb_stage_if.master dmem,
    output logic        StallM,
    output logic        MisalignM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic [2:0]  CtrlW
);

    mem_state_e  r_state;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_access;
    logic        w_misalign;
    logic        w_legal_access;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic [2:0]  w_ctrl_w;

    assign w_addr_lo  = ALUResultM[1:0];
    assign w_is_load  = (CtrlM[CTRLM_RES_HI:CTRLM_RES_LO] == RES_LOAD);
    assign w_is_store = CtrlM[CTRLM_MEMWRITE];
    assign w_access   = w_is_load | w_is_store;
    assign w_ctrl_w   = {CtrlM[CTRLM_REGWRITE], CtrlM[CTRLM_RES_HI:CTRLM_RES_LO]};

    always_comb begin
        w_misalign = 1'b0;
        if (w_access) begin
            if (!f3_legal(Funct3M, w_is_load))
                w_misalign = 1'b1;
            else if ((Funct3M == F3_H || Funct3M == F3_HU) && w_addr_lo[0])
                w_misalign = 1'b1;
            else if (Funct3M == F3_W && w_addr_lo != 2'b00)
                w_misalign = 1'b1;
        end
    end

    assign w_legal_access = w_access & ~w_misalign;

    // Store lanes: data is replicated across lanes so memory just honours be.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        if (w_is_load) begin
            w_be = 4'b1111;
        end else begin
            case (Funct3M)
                F3_B: begin
                    w_be    = 4'b0001 << w_addr_lo;
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                F3_H: begin
                    w_be    = w_addr_lo[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                F3_W:    w_be = 4'b1111;
                default: w_be = 4'b0000;
            endcase
        end
    end

    load_align u_load_align (
        .i_rdata   (dmem.dmem_rdata),
        .i_addr_lo (w_addr_lo),
        .i_funct3  (Funct3M),
        .o_data    (w_load_data)
    );

    // Request and stall are gated by rst so they drop the instant reset asserts.
    // Address/data/enables stay stable in WAIT because upstream holds the M inputs.
    assign dmem.dmem_req   = ~rst & (((r_state == IDLE) & w_legal_access) | (r_state == WAIT));
    assign dmem.dmem_we    = w_is_store;
    assign dmem.dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem.dmem_be    = w_be;
    assign dmem.dmem_wdata = w_wdata;

    assign StallM    = ~rst & (((r_state == IDLE) & w_legal_access) |
                               ((r_state == WAIT) & ~dmem.dmem_rvalid));
    assign MisalignM = w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            PCPlus4W   <= 32'h0;
            RdW        <= 5'h0;
            CtrlW      <= 3'h0;
        end else begin
            // Bubble by default; overridden when an instruction retires into W.
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            PCPlus4W   <= 32'h0;
            RdW        <= 5'h0;
            CtrlW      <= 3'h0;
            if (r_state == IDLE) begin
                if (w_legal_access) begin
                    r_state <= WAIT;
                end else if (!w_misalign) begin
                    ALUResultW <= ALUResultM;
                    PCPlus4W   <= PCPlus4M;
                    RdW        <= RdM;
                    CtrlW      <= w_ctrl_w;
                end
            end else begin
                if (dmem.dmem_rvalid) begin
                    r_state    <= IDLE;
                    ALUResultW <= ALUResultM;
                    ReadDataW  <= w_is_load ? w_load_data : 32'h0;
                    PCPlus4W   <= PCPlus4M;
                    RdW        <= RdM;
                    CtrlW      <= w_ctrl_w;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic [3:0]  CtrlM;
    logic [2:0]  Funct3M;
    logic        StallM;
    logic        MisalignM;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [2:0]  CtrlW;

    int tests;
    int fails;

    mem_wb_stage_if dmem();

    mem_wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M),
        .CtrlM      (CtrlM),
        .Funct3M    (Funct3M),
        .dmem       (dmem.master),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .CtrlW      (CtrlW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        int          lat;       // 0 = no bus transaction expected
        logic [31:0] rdata;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [2:0]  exp_ctrlw;
        logic [31:0] exp_rdw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_nop();
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        RdM        = 5'h0;
        PCPlus4M   = 32'h0;
        CtrlM      = 4'h0;
        Funct3M    = 3'h0;
    endtask

    task automatic check_w(input vec_t v);
        chk({v.name, " ALUResultW"}, ALUResultW, v.exp_mis ? 32'h0 : v.addr);
        chk({v.name, " PCPlus4W"},   PCPlus4W,   v.exp_mis ? 32'h0 : v.pc4);
        chk({v.name, " RdW"},        {27'h0, RdW}, v.exp_mis ? 32'h0 : {27'h0, v.rd});
        chk({v.name, " CtrlW"},      {29'h0, CtrlW}, {29'h0, v.exp_ctrlw});
        chk({v.name, " ReadDataW"},  ReadDataW,  v.exp_rdw);
    endtask

    // Entered at posedge+1; returns at posedge+1 after W has captured the instruction.
    task automatic run_vec(input vec_t v);
        int stall_cnt;
        ALUResultM = v.addr;
        WriteDataM = v.wdata;
        RdM        = v.rd;
        PCPlus4M   = v.pc4;
        CtrlM      = v.ctrl;
        Funct3M    = v.f3;
        dmem.dmem_rvalid = 1'b0;
        if (v.lat == 0) begin
            @(negedge clk);
            chk({v.name, " StallM"},    {31'h0, StallM}, 32'h0);
            chk({v.name, " MisalignM"}, {31'h0, MisalignM}, {31'h0, v.exp_mis});
            chk({v.name, " dmem_req"},  {31'h0, dmem.dmem_req}, 32'h0);
            @(posedge clk); #1;
            check_w(v);
        end else begin
            stall_cnt = 0;
            for (int c = 0; c <= v.lat; c++) begin
                if (c == v.lat) begin
                    dmem.dmem_rvalid = 1'b1;
                    dmem.dmem_rdata  = v.rdata;
                end
                @(negedge clk);
                if (StallM) stall_cnt++;
                if (c == 0) begin
                    chk({v.name, " dmem_req"},  {31'h0, dmem.dmem_req}, 32'h1);
                    chk({v.name, " MisalignM"}, {31'h0, MisalignM}, 32'h0);
                    chk({v.name, " dmem_we"},   {31'h0, dmem.dmem_we}, {31'h0, v.ctrl[0]});
                    chk({v.name, " dmem_addr"}, dmem.dmem_addr, {v.addr[31:2], 2'b00});
                    chk({v.name, " dmem_be"},   {28'h0, dmem.dmem_be}, {28'h0, v.exp_be});
                    if (v.ctrl[0]) chk({v.name, " dmem_wdata"}, dmem.dmem_wdata, v.exp_wdata);
                end else begin
                    chk({v.name, " req held"},  {31'h0, dmem.dmem_req}, 32'h1);
                    chk({v.name, " addr held"}, dmem.dmem_addr, {v.addr[31:2], 2'b00});
                    chk({v.name, " W bubble"},  {29'h0, CtrlW}, 32'h0);
                end
                @(posedge clk); #1;
            end
            dmem.dmem_rvalid = 1'b0;
            dmem.dmem_rdata  = 32'h5A5A5A5A;
            chk({v.name, " stall cycles"}, stall_cnt, v.lat);
            check_w(v);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = 32'h0;
        drive_nop();

        //            name        ctrl     f3     addr          wdata         rd  pc4     lat rdata         mis   be       wdata_exp     ctrlw   rdw
        vecs.push_back('{"alu",   4'b1000, 3'b000, 32'h00001234, 32'h0,        5,  32'h40, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        3'b100, 32'h0});
        vecs.push_back('{"lb",    4'b1010, 3'b000, 32'h00000103, 32'h0,        7,  32'h44, 2, 32'h80123456, 1'b0, 4'b1111, 32'h0,        3'b101, 32'hFFFFFF80});
        vecs.push_back('{"lbu",   4'b1010, 3'b100, 32'h00000103, 32'h0,        8,  32'h48, 2, 32'h80123456, 1'b0, 4'b1111, 32'h0,        3'b101, 32'h00000080});
        vecs.push_back('{"sh",    4'b0001, 3'b001, 32'h00000202, 32'hABCD1234, 3,  32'h4C, 1, 32'h55555555, 1'b0, 4'b1100, 32'h12341234, 3'b000, 32'h0});
        vecs.push_back('{"lwmis", 4'b1010, 3'b010, 32'h00000301, 32'h0,        6,  32'h50, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        3'b000, 32'h0});
        vecs.push_back('{"lh",    4'b1010, 3'b001, 32'h00000402, 32'h0,        9,  32'h54, 1, 32'h80017FFF, 1'b0, 4'b1111, 32'h0,        3'b101, 32'hFFFF8001});
        vecs.push_back('{"lhu",   4'b1010, 3'b101, 32'h00000400, 32'h0,        10, 32'h58, 1, 32'h1234F00D, 1'b0, 4'b1111, 32'h0,        3'b101, 32'h0000F00D});
        vecs.push_back('{"lw",    4'b1010, 3'b010, 32'h00000500, 32'h0,        11, 32'h5C, 3, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        3'b101, 32'hDEADBEEF});
        vecs.push_back('{"sb",    4'b0001, 3'b000, 32'h00000601, 32'h000000A5, 2,  32'h60, 1, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 3'b000, 32'h0});
        vecs.push_back('{"sw",    4'b0001, 3'b010, 32'h00000700, 32'hCAFEF00D, 4,  32'h64, 1, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 3'b000, 32'h0});
        vecs.push_back('{"jal",   4'b1100, 3'b000, 32'h00000099, 32'h0,        1,  32'h88, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        3'b110, 32'h0});
        vecs.push_back('{"lhmis", 4'b1010, 3'b001, 32'h00000803, 32'h0,        13, 32'h6C, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        3'b000, 32'h0});
        vecs.push_back('{"f3bad", 4'b1010, 3'b011, 32'h00000900, 32'h0,        14, 32'h70, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        3'b000, 32'h0});
        vecs.push_back('{"lbpos", 4'b1010, 3'b000, 32'h00000101, 32'h0,        15, 32'h74, 1, 32'h80123456, 1'b0, 4'b1111, 32'h0,        3'b101, 32'h00000034});

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset StallM",     {31'h0, StallM}, 32'h0);
        chk("reset dmem_req",   {31'h0, dmem.dmem_req}, 32'h0);
        chk("reset ALUResultW", ALUResultW, 32'h0);
        chk("reset ReadDataW",  ReadDataW, 32'h0);
        chk("reset CtrlW",      {29'h0, CtrlW}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors (consecutive vectors also exercise back-to-back issue)
        foreach (vecs[i]) run_vec(vecs[i]);
        drive_nop();
        @(posedge clk); #1;

        // Explicit back-to-back: sw then lw, 1-cycle latency each
        ALUResultM = 32'h10; WriteDataM = 32'h0BADF00D; RdM = 5'd0; PCPlus4M = 32'h100;
        CtrlM = 4'b0001; Funct3M = 3'b010;
        @(negedge clk);
        chk("b2b sw req", {31'h0, dmem.dmem_req}, 32'h1);
        chk("b2b sw we",  {31'h0, dmem.dmem_we}, 32'h1);
        @(posedge clk); #1;
        dmem.dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("b2b sw rvalid stall", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        dmem.dmem_rvalid = 1'b0;
        ALUResultM = 32'h14; WriteDataM = 32'h0; RdM = 5'd12; PCPlus4M = 32'h104;
        CtrlM = 4'b1010; Funct3M = 3'b010;
        @(negedge clk);
        chk("b2b lw req next cycle", {31'h0, dmem.dmem_req}, 32'h1);
        chk("b2b lw we",             {31'h0, dmem.dmem_we}, 32'h0);
        chk("b2b lw addr",           dmem.dmem_addr, 32'h14);
        chk("b2b lw stall",          {31'h0, StallM}, 32'h1);
        chk("b2b sw ALUResultW",     ALUResultW, 32'h10);
        chk("b2b sw CtrlW",          {29'h0, CtrlW}, 32'h0);
        @(posedge clk); #1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'h11223344;
        @(posedge clk); #1;
        dmem.dmem_rvalid = 1'b0;
        drive_nop();
        chk("b2b lw ReadDataW", ReadDataW, 32'h11223344);
        chk("b2b lw RdW",       {27'h0, RdW}, 32'd12);
        chk("b2b lw CtrlW",     {29'h0, CtrlW}, 32'b101);

        // Asynchronous reset clears a populated W register mid-cycle
        ALUResultM = 32'hABC; RdM = 5'd4; PCPlus4M = 32'h200; CtrlM = 4'b1000; Funct3M = 3'b000;
        @(posedge clk); #1;
        drive_nop();
        chk("pre-rst ALUResultW", ALUResultW, 32'hABC);
        #2 rst = 1'b1;
        #1;
        chk("async rst ALUResultW", ALUResultW, 32'h0);
        chk("async rst RdW",        {27'h0, RdW}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-WAIT, then a stray rvalid
        @(posedge clk); #1;
        ALUResultM = 32'h20; RdM = 5'd9; PCPlus4M = 32'h300; CtrlM = 4'b1010; Funct3M = 3'b010;
        @(posedge clk); #1;
        chk("wait req",   {31'h0, dmem.dmem_req}, 32'h1);
        chk("wait stall", {31'h0, StallM}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst-wait req drop",   {31'h0, dmem.dmem_req}, 32'h0);
        chk("rst-wait stall drop", {31'h0, StallM}, 32'h0);
        chk("rst-wait CtrlW",      {29'h0, CtrlW}, 32'h0);
        @(negedge clk);
        chk("rst held req", {31'h0, dmem.dmem_req}, 32'h0);
        drive_nop();
        rst = 1'b0;
        @(posedge clk); #1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        chk("stray rvalid req",   {31'h0, dmem.dmem_req}, 32'h0);
        chk("stray rvalid stall", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        dmem.dmem_rvalid = 1'b0;
        chk("stray rvalid CtrlW",     {29'h0, CtrlW}, 32'h0);
        chk("stray rvalid ReadDataW", ReadDataW, 32'h0);
        chk("stray rvalid RdW",       {27'h0, RdW}, 32'h0);

        // FSM is back in IDLE: a fresh load behaves normally
        run_vec(vecs[5]);
        drive_nop();
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
